// File: rtl/hazard_pkg.sv
// Shared encodings and slot layout for the five-stage pipeline hazard tracker.
package hazard_pkg;

  // Tuse value meaning "this operand is not read by the instruction".
  localparam logic [1:0] TUSE_NONE = 2'b11;

  // Operand source selects.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // Tnew on entry to E: lui/jal results are ready at once, ALU ops after E, lw after M.
  typedef enum logic [1:0] {
    TNEW_IMM  = 2'd0,
    TNEW_ALU  = 2'd1,
    TNEW_LOAD = 2'd2
  } tnew_e;

  // How a slot register treats the incoming Tnew as the instruction moves in.
  typedef enum logic [1:0] {
    TNEW_KEEP  = 2'd0,
    TNEW_DEC   = 2'd1,
    TNEW_CLEAR = 2'd2
  } tnew_mode_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{rs: 5'd0, rt: 5'd0, dst: 5'd0, tnew: 2'd0};

  // Tnew seen by the next stage: unchanged, one less (floored at zero), or zero.
  function automatic logic [1:0] next_tnew(input tnew_mode_e mode, input logic [1:0] tnew);
    logic [1:0] res;
    case (mode)
      TNEW_KEEP:  res = tnew;
      TNEW_DEC:   res = (tnew == 2'd0) ? 2'd0 : (tnew - 2'd1);
      TNEW_CLEAR: res = 2'd0;
      default:    res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One pipeline slot {rs, rt, dst, tnew} with synchronous clear, bubble insertion
// and a per-stage Tnew adjustment chosen at elaboration time.
module hazard_slot_reg
  import hazard_pkg::*;
#(
  parameter tnew_mode_e MODE = TNEW_KEEP
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble,
  input  slot_t din,
  output slot_t q
);

  slot_t slot_r;
  slot_t next_s;

  // Incoming slot contents: an empty bubble, or the upstream fields with adjusted Tnew.
  always_comb begin
    next_s = SLOT_EMPTY;
    if (bubble) begin
      next_s = SLOT_EMPTY;
    end else begin
      next_s      = din;
      next_s.tnew = next_tnew(MODE, din.tnew);
    end
  end

  // Slot register, cleared while reset is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_r <= SLOT_EMPTY;
    end else begin
      slot_r <= next_s;
    end
  end

  assign q = slot_r;

endmodule

// File: rtl/hazard_tracker.sv
// Hazard tracker: follows each instruction's destination and Tnew through E, M
// and W, stalls D on unresolvable RAW hazards and picks forwarding sources.
module hazard_tracker
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rsTuse,
  input  logic [1:0] D_rtTuse,
  input  logic       D_regWE,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_tnew,
  output logic       stall,
  output logic [1:0] D_fwdRs,
  output logic [1:0] D_fwdRt,
  output logic [1:0] E_fwdRs,
  output logic [1:0] E_fwdRt,
  output logic [1:0] M_fwdRt,
  output logic [4:0] E_dst,
  output logic [4:0] M_dst,
  output logic [4:0] W_dst
);

  slot_t d_slot_s;
  slot_t e_slot_s;
  slot_t m_slot_s;
  slot_t w_slot_s;

  // A slot can supply src when it writes that (non-zero) register and its value exists.
  function automatic logic fwd_hit(input slot_t s, input logic [4:0] src);
    return (s.dst != 5'd0) && (s.dst == src) && (s.tnew == 2'd0);
  endfunction

  // An operand stalls when a producer in E or M cannot deliver before the operand is needed.
  function automatic logic op_stall(input logic [4:0] src, input logic [1:0] tuse,
                                    input slot_t e, input slot_t m);
    logic qualifies;
    qualifies = (src != 5'd0) && (tuse != TUSE_NONE);
    return qualifies && (((e.dst == src) && (e.tnew > tuse)) ||
                         ((m.dst == src) && (m.tnew > tuse)));
  endfunction

  // D-stage source: the youngest ready producer wins.
  function automatic logic [1:0] d_sel(input logic [4:0] src, input slot_t e,
                                       input slot_t m, input slot_t w);
    logic [1:0] sel;
    if (fwd_hit(e, src)) begin
      sel = FWD_E;
    end else if (fwd_hit(m, src)) begin
      sel = FWD_M;
    end else if (fwd_hit(w, src)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // E-stage source: M ahead of W.
  function automatic logic [1:0] e_sel(input logic [4:0] src, input slot_t m, input slot_t w);
    logic [1:0] sel;
    if (fwd_hit(m, src)) begin
      sel = FWD_M;
    end else if (fwd_hit(w, src)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Pack the D instruction; non-writing instructions carry no destination.
  always_comb begin
    d_slot_s      = SLOT_EMPTY;
    d_slot_s.rs   = D_rs;
    d_slot_s.rt   = D_rt;
    d_slot_s.tnew = D_tnew;
    if (D_regWE) begin
      d_slot_s.dst = D_dst;
    end else begin
      d_slot_s.dst = 5'd0;
    end
  end

  // E takes the D instruction as-is, or a bubble while D is held.
  hazard_slot_reg #(.MODE(TNEW_KEEP)) u_slot_e (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall),
    .din    (d_slot_s),
    .q      (e_slot_s)
  );

  // M: one stage closer to having the result.
  hazard_slot_reg #(.MODE(TNEW_DEC)) u_slot_m (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .din    (e_slot_s),
    .q      (m_slot_s)
  );

  // W: every result is available.
  hazard_slot_reg #(.MODE(TNEW_CLEAR)) u_slot_w (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .din    (m_slot_s),
    .q      (w_slot_s)
  );

  // Stall and forwarding selects from the current slots and the D operands.
  always_comb begin
    stall   = op_stall(D_rs, D_rsTuse, e_slot_s, m_slot_s) |
              op_stall(D_rt, D_rtTuse, e_slot_s, m_slot_s);
    D_fwdRs = d_sel(D_rs, e_slot_s, m_slot_s, w_slot_s);
    D_fwdRt = d_sel(D_rt, e_slot_s, m_slot_s, w_slot_s);
    E_fwdRs = e_sel(e_slot_s.rs, m_slot_s, w_slot_s);
    E_fwdRt = e_sel(e_slot_s.rt, m_slot_s, w_slot_s);
    if (fwd_hit(w_slot_s, m_slot_s.rt)) begin
      M_fwdRt = FWD_W;
    end else begin
      M_fwdRt = FWD_RF;
    end
  end

  assign E_dst = e_slot_s.dst;
  assign M_dst = m_slot_s.dst;
  assign W_dst = w_slot_s.dst;

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: a hand-derived cycle trace table,
// then randomized traffic against an instruction-level reference model.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_dst;
  logic [1:0] D_rsTuse, D_rtTuse, D_tnew;
  logic       D_regWE;
  logic       stall;
  logic [1:0] D_fwdRs, D_fwdRt, E_fwdRs, E_fwdRt, M_fwdRt;
  logic [4:0] E_dst, M_dst, W_dst;

  hazard_tracker dut (
    .clk      (clk),
    .reset    (reset),
    .D_rs     (D_rs),
    .D_rt     (D_rt),
    .D_rsTuse (D_rsTuse),
    .D_rtTuse (D_rtTuse),
    .D_regWE  (D_regWE),
    .D_dst    (D_dst),
    .D_tnew   (D_tnew),
    .stall    (stall),
    .D_fwdRs  (D_fwdRs),
    .D_fwdRt  (D_fwdRt),
    .E_fwdRs  (E_fwdRs),
    .E_fwdRt  (E_fwdRt),
    .M_fwdRt  (M_fwdRt),
    .E_dst    (E_dst),
    .M_dst    (M_dst),
    .W_dst    (W_dst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // One cycle of the directed trace: D inputs and the outputs expected that cycle.
  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic [1:0] rs_tuse, rt_tuse;
    logic       we;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       chk;
    logic [25:0] exp;
  } vec_t;

  function automatic vec_t mk(int rst, int rs, int rt, int rsu, int rtu, int we, int dst,
                              int tn, int chk, int st, int dfs, int dft, int efs, int eft,
                              int mft, int ed, int md, int wd);
    vec_t v;
    v.rst = 1'(rst);  v.rs = 5'(rs);  v.rt = 5'(rt);
    v.rs_tuse = 2'(rsu);  v.rt_tuse = 2'(rtu);
    v.we = 1'(we);  v.dst = 5'(dst);  v.tnew = 2'(tn);  v.chk = 1'(chk);
    v.exp = {1'(st), 2'(dfs), 2'(dft), 2'(efs), 2'(eft), 2'(mft), 5'(ed), 5'(md), 5'(wd)};
    return v;
  endfunction

  function automatic logic [25:0] outs();
    return {stall, D_fwdRs, D_fwdRt, E_fwdRs, E_fwdRt, M_fwdRt, E_dst, M_dst, W_dst};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {stall,dRs,dRt,eRs,eRt,mRt,Ed,Md,Wd}=%b_%0d_%0d_%0d_%0d_%0d_%0d_%0d_%0d required %b_%0d_%0d_%0d_%0d_%0d_%0d_%0d_%0d",
               name, act[25], act[24:23], act[22:21], act[20:19], act[18:17], act[16:15],
               act[14:10], act[9:5], act[4:0], exp[25], exp[24:23], exp[22:21], exp[20:19],
               exp[18:17], exp[16:15], exp[14:10], exp[9:5], exp[4:0]);
    end
  endtask

  // Reference model: the instructions sitting in E, M, W (index = cycles since entering E)
  // with the Tnew they had when they entered E.
  typedef struct {
    int rs;
    int rt;
    int dst;
    int tnew0;
  } minstr_t;

  minstr_t pipe[3];
  minstr_t empty_i = '{0, 0, 0, 0};

  // Cycles still needed before the result of the instruction at age k exists.
  function automatic int remaining(input int k);
    return (pipe[k].tnew0 > k) ? (pipe[k].tnew0 - k) : 0;
  endfunction

  // The youngest stage (from age lo upward) holding a ready result for reg; 0 if none.
  function automatic int youngest_ready(input int lo, input int reg_no);
    for (int k = lo; k < 3; k++) begin
      if (reg_no != 0 && pipe[k].dst == reg_no && remaining(k) == 0) return k + 1;
    end
    return 0;
  endfunction

  function automatic logic model_stall(input int rs, input int rt, input int rsu, input int rtu);
    logic st = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (rs != 0 && rsu != 3 && pipe[k].dst == rs && remaining(k) > rsu) st = 1'b1;
      if (rt != 0 && rtu != 3 && pipe[k].dst == rt && remaining(k) > rtu) st = 1'b1;
    end
    return st;
  endfunction

  function automatic logic [25:0] model_exp(input int rs, input int rt, input int rsu, input int rtu);
    int mft;
    mft = (pipe[2].dst != 0 && pipe[2].dst == pipe[1].rt) ? 3 : 0;
    return {model_stall(rs, rt, rsu, rtu),
            2'(youngest_ready(0, rs)), 2'(youngest_ready(0, rt)),
            2'(youngest_ready(1, pipe[0].rs)), 2'(youngest_ready(1, pipe[0].rt)),
            2'(mft), 5'(pipe[0].dst), 5'(pipe[1].dst), 5'(pipe[2].dst)};
  endfunction

  vec_t tbl[24];

  initial begin
    // rst rs rt rsU rtU we dst tn chk | st dRs dRt eRs eRt mRt Ed Md Wd
    tbl[0]  = mk(0,  8,  9, 0, 0, 1,  8, 2, 0,  0, 0, 0, 0, 0, 0,  0,  0,  0);
    tbl[1]  = mk(0,  8,  9, 0, 0, 1,  8, 2, 1,  0, 0, 0, 0, 0, 0,  0,  0,  0);
    tbl[2]  = mk(1, 29,  0, 1, 3, 1,  8, 2, 1,  0, 0, 0, 0, 0, 0,  0,  0,  0); // lw $8
    tbl[3]  = mk(1,  8, 10, 1, 1, 1, 11, 1, 1,  1, 0, 0, 0, 0, 0,  8,  0,  0); // add uses $8
    tbl[4]  = mk(1,  8, 10, 1, 1, 1, 11, 1, 1,  0, 0, 0, 0, 0, 0,  0,  8,  0);
    tbl[5]  = mk(1,  0,  0, 3, 3, 0,  0, 0, 1,  0, 0, 0, 3, 0, 0, 11,  0,  8);
    tbl[6]  = mk(1, 29,  0, 1, 3, 1,  9, 2, 1,  0, 0, 0, 0, 0, 0,  0, 11,  0); // lw $9
    tbl[7]  = mk(1,  9,  0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 0, 0, 0,  9,  0, 11); // beq $9
    tbl[8]  = mk(1,  9,  0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 0, 0, 0,  0,  9,  0);
    tbl[9]  = mk(1,  9,  0, 0, 0, 0,  0, 0, 1,  0, 3, 0, 0, 0, 0,  0,  0,  9);
    tbl[10] = mk(1,  0,  0, 1, 3, 1,  5, 1, 1,  0, 0, 0, 0, 0, 0,  0,  0,  0); // ori $5
    tbl[11] = mk(1,  5,  5, 1, 1, 1,  6, 1, 1,  0, 0, 0, 0, 0, 0,  5,  0,  0); // add $6,$5,$5
    tbl[12] = mk(1,  0,  0, 3, 3, 0,  0, 0, 1,  0, 0, 0, 2, 2, 0,  6,  5,  0);
    tbl[13] = mk(1,  1,  2, 1, 1, 1,  0, 1, 1,  0, 0, 0, 0, 0, 3,  0,  6,  5); // add $0
    tbl[14] = mk(1,  0,  0, 0, 0, 0,  7, 0, 1,  0, 0, 0, 0, 0, 0,  0,  0,  6); // use $0, no write
    tbl[15] = mk(1,  0,  0, 3, 3, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0,  0,  0,  0);
    tbl[16] = mk(1, 29,  0, 1, 3, 1,  9, 2, 1,  0, 0, 0, 0, 0, 0,  0,  0,  0); // lw $9
    tbl[17] = mk(1,  9,  0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 0, 0, 0,  9,  0,  0); // beq $9
    tbl[18] = mk(0,  9,  0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 0, 0, 0,  0,  9,  0); // reset mid-stall
    tbl[19] = mk(1,  9,  0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0,  0,  0,  0);
    tbl[20] = mk(1, 29,  0, 1, 3, 1,  3, 2, 1,  0, 0, 0, 0, 0, 0,  0,  0,  0); // lw $3
    tbl[21] = mk(1,  1,  0, 1, 3, 1,  4, 1, 1,  0, 0, 0, 0, 0, 0,  3,  0,  0); // add $4
    tbl[22] = mk(1,  4,  3, 0, 0, 0,  0, 0, 1,  1, 0, 0, 0, 0, 0,  4,  3,  0); // beq $4,$3
    tbl[23] = mk(1,  4,  3, 0, 0, 0,  0, 0, 1,  0, 2, 3, 0, 0, 0,  0,  4,  3);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      reset = tbl[i].rst;  D_rs = tbl[i].rs;  D_rt = tbl[i].rt;
      D_rsTuse = tbl[i].rs_tuse;  D_rtTuse = tbl[i].rt_tuse;
      D_regWE = tbl[i].we;  D_dst = tbl[i].dst;  D_tnew = tbl[i].tnew;
      #1;
      if (tbl[i].chk) check($sformatf("trace_row%0d", i), outs(), tbl[i].exp);
    end

    // Randomized traffic; the first cycle resets both DUT and model into step.
    for (int k = 0; k < 3; k++) pipe[k] = empty_i;
    for (int i = 0; i < 3000; i++) begin
      logic st;
      @(negedge clk);
      reset    = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      D_rs     = 5'($urandom_range(0, 7));
      D_rt     = 5'($urandom_range(0, 7));
      D_rsTuse = 2'($urandom_range(0, 3));
      D_rtTuse = 2'($urandom_range(0, 3));
      D_regWE  = 1'($urandom_range(0, 1));
      D_dst    = 5'($urandom_range(0, 7));
      D_tnew   = 2'($urandom_range(0, 2));
      #1;
      if (i > 0) check($sformatf("random_cycle%0d", i), outs(),
                       model_exp(int'(D_rs), int'(D_rt), int'(D_rsTuse), int'(D_rtTuse)));
      st = model_stall(int'(D_rs), int'(D_rt), int'(D_rsTuse), int'(D_rtTuse));
      if (!reset) begin
        for (int k = 0; k < 3; k++) pipe[k] = empty_i;
      end else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st) pipe[0] = empty_i;
        else pipe[0] = '{int'(D_rs), int'(D_rt), D_regWE ? int'(D_dst) : 0, int'(D_tnew)};
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
